lsu_dmem_port: RTL and testbench

Load/store unit front-end sitting between the CPU execute stage and the byte-banked data memory. Accepts one load or store request at a time over a valid/ready handshake, generates the word address, byte-lane write enables and lane-replicated write data the memory expects, then extracts, aligns and sign/zero-extends load data from the 32-bit memory read word. Returns a registered response carrying read data and an error code for illegal-size, out-of-range or misaligned accesses.

---
 rtl/lsu_dmem_port.sv | 136 +++++++++++++
 tb/tb_lsu_dmem_port.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_port.sv
// Load/store unit front-end for a byte-banked 32-bit data memory.
// One request in flight: IDLE accepts, ACCESS drives the memory, RESP holds the response.
module lsu_dmem_port #(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
  parameter int unsigned DMEM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_BYTES);
  localparam logic [1:0]  ERR_OK    = 2'b00;
  localparam logic [1:0]  ERR_ALIGN = 2'b01;
  localparam logic [1:0]  ERR_RANGE = 2'b10;
  localparam logic [1:0]  ERR_SIZE  = 2'b11;

  state_t      state, state_nxt;
  logic        we_q, uns_q;
  logic [1:0]  size_q, err_q;
  logic [3:0]  mask_q;
  logic [31:0] off_q, dwdata_q, rdata_q;
  logic [1:0]  rerr_q;

  logic [31:0] req_off;
  logic [1:0]  req_err;
  logic [3:0]  req_mask;
  logic [31:0] req_rep;
  logic [31:0] ld_word;
  logic [31:0] ld_data;

  // Offset wraps modulo 2^32, so addresses below the base land far out of range.
  assign req_off = req_addr - DMEM_BASE;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req_err  = ERR_OK;
    req_mask = 4'b0000;
    req_rep  = req_wdata;
    if (req_size == 2'b11)
      req_err = ERR_SIZE;
    else if (req_off >= DMEM_LIMIT)
      req_err = ERR_RANGE;
    else if ((req_size == 2'b01 && req_off[0]) || (req_size == 2'b10 && req_off[1:0] != 2'b00))
      req_err = ERR_ALIGN;
    case (req_size)
      2'b00: begin
        req_mask = 4'b0001 << req_off[1:0];
        req_rep  = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_mask = req_off[1] ? 4'b1100 : 4'b0011;
        req_rep  = {2{req_wdata[15:0]}};
      end
      2'b10:   req_mask = 4'b1111;
      default: req_mask = 4'b0000;
    endcase
  end

  always_comb begin
    ld_word = drdata >> {off_q[1:0], 3'b000};
    ld_data = drdata;
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'h0, ld_word[7:0]} : {{24{ld_word[7]}}, ld_word[7:0]};
      2'b01:   ld_data = uns_q ? {16'h0, ld_word[15:0]} : {{16{ld_word[15]}}, ld_word[15:0]};
      default: ld_data = drdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= 2'b00;
      err_q    <= ERR_OK;
      mask_q   <= 4'b0000;
      off_q    <= 32'h0;
      dwdata_q <= 32'h0;
      rdata_q  <= 32'h0;
      rerr_q   <= ERR_OK;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req_valid) begin
        we_q     <= req_we;
        uns_q    <= req_unsigned;
        size_q   <= req_size;
        err_q    <= req_err;
        mask_q   <= req_mask;
        off_q    <= req_off;
        dwdata_q <= req_rep;
      end
      if (state == S_ACCESS) begin
        rdata_q <= (!we_q && err_q == ERR_OK) ? ld_data : 32'h0;
        rerr_q  <= err_q;
      end
    end
  end

  // Write enables decode straight from state so reset kills them without waiting for a clock.
  assign dwe       = (state == S_ACCESS && we_q && err_q == ERR_OK) ? mask_q : 4'b0000;
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;
  assign daddr     = off_q;
  assign dwdata    = dwdata_q;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Self-checking bench for lsu_dmem_port: a byte-array memory model backs the DUT,
// and a shadow byte array predicts load data, errors and lane enables per request.
module tb_lsu_dmem_port;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          BYTES = 16384;
  localparam int          AW    = $clog2(BYTES);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata, daddr, dwdata, drdata;
  logic [1:0]  rsp_err;
  logic [3:0]  dwe;

  int total = 0;
  int bad = 0;

  logic [7:0] mem     [BYTES];
  logic [7:0] ref_mem [BYTES];
  int         wa;

  always #5 clk = ~clk;

  lsu_dmem_port #(.DMEM_BASE(BASE), .DMEM_BYTES(BYTES)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
  );

  assign wa     = int'(daddr[AW-1:2]) * 4;
  assign drdata = {mem[wa+3], mem[wa+2], mem[wa+1], mem[wa]};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (dwe[i]) mem[wa+i] <= dwdata[8*i +: 8];
  end

  // One request through the DUT; expected values come from the shadow memory model.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                         output logic [31:0] rdata, output logic [1:0] err);
    logic [31:0] off, exp_rd, exp_dwd, got_rd;
    logic [1:0]  exp_err, got_err;
    logic [3:0]  exp_dwe;
    int n, t;
    off = addr - BASE;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (size == 2'd3)             exp_err = 2'b11;
    else if (off >= 32'(BYTES))   exp_err = 2'b10;
    else if (off % n != 0)        exp_err = 2'b01;
    else                          exp_err = 2'b00;
    exp_dwe = 4'b0000;
    exp_rd  = 32'h0;
    for (int i = 0; i < 4; i++) exp_dwd[8*i +: 8] = wdata[8*(i % n) +: 8];
    if (exp_err == 2'b00) begin
      if (we) begin
        for (int i = 0; i < n; i++) begin
          exp_dwe[(off + i) % 4] = 1'b1;
          ref_mem[off + i] = wdata[8*i +: 8];
        end
      end else begin
        for (int i = 0; i < n; i++) exp_rd = exp_rd | (32'(ref_mem[off + i]) << (8 * i));
        if (!uns && exp_rd[8*n-1]) exp_rd = exp_rd | ~((32'h1 << (8 * n)) - 1);
        if (n == 4) exp_rd = {ref_mem[off+3], ref_mem[off+2], ref_mem[off+1], ref_mem[off]};
      end
    end

    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    total++;
    if (t == 20) begin bad++; $display("FAIL req_ready_timeout: got %b want 1", req_ready); end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL access_handshake: got ready=%b valid=%b want 0 0", req_ready, rsp_valid);
    end
    total++;
    if (daddr !== off) begin bad++; $display("FAIL daddr: got %h want %h", daddr, off); end
    total++;
    if (dwe !== exp_dwe) begin bad++; $display("FAIL dwe: got %b want %b", dwe, exp_dwe); end
    if (we && size != 2'd3) begin
      total++;
      if (dwdata !== exp_dwd) begin bad++; $display("FAIL dwdata: got %h want %h", dwdata, exp_dwd); end
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++; $display("FAIL rsp_latency: got valid=%b want 1", rsp_valid);
      t = 0;
      while (!rsp_valid && t < 10) begin @(negedge clk); t++; end
    end
    got_rd = rsp_rdata; got_err = rsp_err;
    if (hold > 0) begin
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== got_rd || rsp_err !== got_err) begin
          bad++;
          $display("FAIL resp_hold: got valid=%b ready=%b rd=%h err=%b want 1 0 %h %b",
                   rsp_valid, req_ready, rsp_rdata, rsp_err, got_rd, got_err);
        end
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL return_idle: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
    total++;
    if (got_rd !== exp_rd) begin bad++; $display("FAIL rsp_rdata: got %h want %h", got_rd, exp_rd); end
    total++;
    if (got_err !== exp_err) begin bad++; $display("FAIL rsp_err: got %b want %b", got_err, exp_err); end
    rdata = got_rd;
    err = got_err;
  endtask

  task automatic test_reset();
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 2'b00 ||
        daddr !== 32'h0 || dwdata !== 32'h0 || dwe !== 4'b0000) begin
      bad++;
      $display("FAIL reset_values: got rdy=%b vld=%b rd=%h err=%b da=%h wd=%h we=%b want 1 0 0 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, daddr, dwdata, dwe);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [1:0]  exp_err;
  } vec_t;

  task automatic test_directed();
    vec_t v [13];
    logic [31:0] rd;
    logic [1:0]  er;
    v[0]  = '{1'b1, 2'd0, 1'b0, BASE + 32'h13, 32'h0000_00A5, 32'h0, 2'b00};
    v[1]  = '{1'b0, 2'd0, 1'b0, BASE + 32'h13, 32'h0, 32'hFFFF_FFA5, 2'b00};
    v[2]  = '{1'b0, 2'd0, 1'b1, BASE + 32'h13, 32'h0, 32'h0000_00A5, 2'b00};
    v[3]  = '{1'b1, 2'd1, 1'b0, BASE + 32'h22, 32'h0000_8001, 32'h0, 2'b00};
    v[4]  = '{1'b0, 2'd1, 1'b0, BASE + 32'h22, 32'h0, 32'hFFFF_8001, 2'b00};
    v[5]  = '{1'b1, 2'd2, 1'b0, BASE + 32'h40, 32'hDEAD_BEEF, 32'h0, 2'b00};
    v[6]  = '{1'b0, 2'd2, 1'b0, BASE + 32'h40, 32'h0, 32'hDEAD_BEEF, 2'b00};
    v[7]  = '{1'b1, 2'd2, 1'b0, BASE + 32'h42, 32'h1234_5678, 32'h0, 2'b01};
    v[8]  = '{1'b0, 2'd2, 1'b0, BASE + 32'h40, 32'h0, 32'hDEAD_BEEF, 2'b00};
    v[9]  = '{1'b1, 2'd3, 1'b0, BASE + 32'h42, 32'h1234_5678, 32'h0, 2'b11};
    v[10] = '{1'b0, 2'd2, 1'b0, BASE + 32'd16384, 32'h0, 32'h0, 2'b10};
    v[11] = '{1'b0, 2'd2, 1'b0, BASE - 32'd4, 32'h0, 32'h0, 2'b10};
    v[12] = '{1'b0, 2'd1, 1'b1, BASE + 32'h23, 32'h0, 32'h0, 2'b01};
    for (int i = 0; i < 13; i++) begin
      run_req(v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wdata, 0, rd, er);
      total++;
      if (rd !== v[i].exp_rd || er !== v[i].exp_err) begin
        bad++;
        $display("FAIL directed_%0d: got rd=%h err=%b want rd=%h err=%b", i, rd, er, v[i].exp_rd, v[i].exp_err);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic [1:0]  er;
    run_req(1'b1, 2'd2, 1'b0, BASE + 32'h100, 32'h8765_4321, 5, rd, er);
    run_req(1'b0, 2'd1, 1'b0, BASE + 32'h102, 32'h0, 5, rd, er);
    total++;
    if (rd !== 32'hFFFF_8765) begin bad++; $display("FAIL backpressure_load: got %h want ffff8765", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr;
    logic [1:0]  er;
    int sel;
    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       addr = BASE + 32'($urandom_range(0, 255));
      else if (sel == 8) addr = BASE + 32'(BYTES) + 32'($urandom_range(0, 64));
      else               addr = BASE - 32'($urandom_range(1, 64));
      run_req(1'($urandom), ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
              1'($urandom), addr, $urandom, $urandom_range(0, 2), rd, er);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd;
    logic [1:0]  er;
    run_req(1'b1, 2'd2, 1'b0, BASE + 32'h80, 32'h1122_3344, 0, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = BASE + 32'h80; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (dwe !== 4'b1111) begin bad++; $display("FAIL abort_pre_dwe: got %b want 1111", dwe); end
    #2 reset = 1'b1;
    #1;
    total++;
    if (dwe !== 4'b0000 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL abort_async: got dwe=%b rdy=%b vld=%b want 0000 1 0", dwe, req_ready, rsp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL abort_no_resp: got vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
    run_req(1'b0, 2'd2, 1'b0, BASE + 32'h80, 32'h0, 0, rd, er);
    total++;
    if (rd !== 32'h1122_3344) begin bad++; $display("FAIL abort_mem_intact: got %h want 11223344", rd); end
  endtask

  initial begin
    for (int i = 0; i < BYTES; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
